// File: rtl/aes_dec_pkg.sv
// Shared AES-128 decrypt definitions: S-box tables, GF(2^8) helpers, Rcon,
// state byte addressing and the controller state type.
package aes_dec_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte (column c, row r) sits at byte index 4c+r, MSB first.
    function automatic int unsigned bidx(input int unsigned c, input int unsigned r);
        return 4 * c + r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned i);
        return s[127 - 8 * i -: 8];
    endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Block-in / block-out handshake bundle of the iterative AES-128 decrypt core.
interface aes_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] dec_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    modport master (
        output in_valid, ciphertext, dec_key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, dec_key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// and InvMixColumns, the last one bypassed for the final round.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_rnd,
    output logic [127:0] state_out
);
    localparam logic [31:0] INV_MIX_COEF = 32'h0e0b0d09;

    logic [127:0] ark;
    logic [127:0] mixed;
    logic [7:0]   col [4];

    always_comb begin
        ark = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                // Row r rotates right by r: take input column (c - r) mod 4.
                ark[127 - 8 * bidx(c, r) -: 8] =
                    inv_sbox(get_byte(state_in, bidx((c + 4 - r) % 4, r)))
                    ^ get_byte(round_key, bidx(c, r));
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int k = 0; k < 4; k++) col[k] = 8'h00;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) col[r] = get_byte(ark, bidx(c, r));
            for (int unsigned r = 0; r < 4; r++) begin
                mixed[127 - 8 * bidx(c, r) -: 8] =
                    gmul(col[r],           INV_MIX_COEF[31:24]) ^
                    gmul(col[(r + 1) % 4], INV_MIX_COEF[23:16]) ^
                    gmul(col[(r + 2) % 4], INV_MIX_COEF[15:8])  ^
                    gmul(col[(r + 3) % 4], INV_MIX_COEF[7:0]);
            end
        end
    end

    assign state_out = final_rnd ? ark : mixed;

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decrypt core: one inverse round per clock with the round
// keys regenerated backwards from the round-10 key.
module aes_dec_iter
    import aes_dec_pkg::*;
#(
    parameter bit CLEAR_OUT = 1'b1
) (
    input logic clk,
    input logic rst,
    aes_dec_iter_if.slave bus
);
    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [3:0]   rnd_q;
    logic         rst_q;

    logic         accept;
    logic         final_rnd;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  w0_p, w1_p, w2_p, w3_p;
    logic [31:0]  rot;

    // Holding in_ready low for the cycle after a reset edge keeps it registered-only.
    assign accept    = (fsm_q == IDLE) && !rst_q && bus.in_valid;
    assign final_rnd = (rnd_q == 4'd1);

    always_comb begin
        {w0, w1, w2, w3} = key_q;
        w3_p = w3 ^ w2;
        w2_p = w2 ^ w1;
        w1_p = w1 ^ w0;
        rot  = {w3_p[23:0], w3_p[31:24]};
        w0_p = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                  ^ {rcon(rnd_q), 24'h000000};
        rk_prev = {w0_p, w1_p, w2_p, w3_p};
    end

    aes_inv_round u_round (
        .state_in  (state_q),
        .round_key (rk_prev),
        .final_rnd (final_rnd),
        .state_out (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (accept) fsm_d = ROUND;
            ROUND:   if (final_rnd) fsm_d = DONE;
            DONE:    if (bus.out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (fsm_q == IDLE) && !rst_q;
        bus.out_valid = (fsm_q == DONE);
        bus.busy      = (fsm_q == ROUND) || (fsm_q == DONE);
        bus.plaintext = (CLEAR_OUT && (fsm_q != DONE)) ? 128'h0 : state_q;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= bus.ciphertext ^ bus.dec_key;
                        key_q   <= bus.dec_key;
                        rnd_q   <= 4'd10;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    key_q   <= rk_prev;
                    rnd_q   <= rnd_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_dec_iter.md
Name: aes_dec_iter

Overview:
Iterative AES-128 inverse cipher (decryption) core. It computes one round per clock and produces the round keys on the fly with a reverse key schedule, so no round-key storage is needed. It is the decrypt-direction counterpart of the encryption datapath and shares the same 128-bit state convention:
- Column-major, MSB-first bytes.
- byte i = bits [127-8i -: 8].
- Column c = bytes 4c..4c+3.
- Row r of column c = byte 4c+r.

Parameters:
- CLEAR_OUT, 1: when 1, plaintext is driven to 0 whenever out_valid=0. When 0, plaintext shows the internal state register.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  ciphertext and dec_key are valid
- in_ready  output  1  core can accept a block (high only in IDLE)
- ciphertext  input  128  block to decrypt, same byte layout as above
- dec_key  input  128  AES-128 round-10 key (last expanded round key)
- out_valid  output  1  plaintext is valid
- out_ready  input  1  downstream accepts plaintext
- plaintext  output  128  decrypted block
- busy  output  1  high in ROUND or DONE

Behaviour:
- Reset: FSM goes to IDLE. Outputs: in_ready=0 during the reset cycle and 1 on the first cycle after it; out_valid=0, busy=0, plaintext=0; the round counter is cleared.
- Reset mid-operation: the block is abandoned with no output, and the core returns to IDLE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid=1: state <= ciphertext ^ dec_key, key <= dec_key, rnd <= 10, go to ROUND.
- ROUND (one edge per round, rnd counts 10 down to 1):
  - Round key: rk_prev = reverse key step of key using Rcon[rnd]. With words w0..w3 (MSB first):
    - w3' = w3^w2
    - w2' = w2^w1
    - w1' = w1^w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[rnd],24'h0}
    - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - rnd > 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev).
  - rnd == 1 (final round): state <= InvSubBytes(InvShiftRows(state)) ^ rk_prev, with no InvMixColumns. Go to DONE.
  - key <= rk_prev and rnd <= rnd-1 on every ROUND edge.
  - InvShiftRows: row r rotates right by r positions. Output byte (col c, row r) = input byte (col (c-r) mod 4, row r).
  - InvMixColumns matrix: [0e 0b 0d 09] circulant over GF(2^8), polynomial 0x11b.
- Latency: if the acceptance edge is E0, ROUND edges are E1..E10 and out_valid=1 from the cycle after E10. That is a fixed 10 cycles with no stalls inside ROUND.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - plaintext holds stable while out_ready=0 (back-pressure of any length).
  - On an edge where out_ready=1: go to IDLE and out_valid <= 0.
  - A new block can be accepted at the earliest one edge after the output handshake. Throughput is 12 cycles per block minimum.
- in_valid while not in IDLE: ignored, and ciphertext/dec_key are not sampled. Changes to the inputs after acceptance have no effect.
- out_ready while out_valid=0: no effect.
- Combinational paths: there is no path from any input to any output. in_ready, out_valid and busy decode registered state only.

Decomposition:
- Package aes_dec_pkg holds:
  - The 256-entry SBOX and INV_SBOX functions.
  - The rcon(rnd) function.
  - The xtime and gmul helper functions.
  - The byte-index helper for the state layout.
  - The FSM state enum IDLE/ROUND/DONE.
- One combinational sub-module, aes_inv_round:
  - Inputs: state, round key, final flag.
  - Output: next state.
  - Contains InvShiftRows, InvSubBytes, AddRoundKey and the bypassable InvMixColumns.
- The reverse key step and the FSM stay in the top module.

Test Plan:
1. FIPS-197 App. C.1: ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, dec_key=13111d7fe3944a17f307a78b4d2b30c5 -> plaintext=00112233445566778899aabbccddeeff, with out_valid exactly 10 cycles after the acceptance edge.
2. FIPS-197 App. B: ciphertext=3925841d02dc09fbdc118597196a0b32, dec_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> plaintext=3243f6a8885a308d313198a2e0370734.
3. Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> plaintext, out_valid=1 and in_ready=0 all stay stable. Pulse out_ready -> out_valid=0 and in_ready=1 on the next cycle.
4. Input robustness: toggle in_valid and change ciphertext during ROUND -> the result still equals the vector of scenario 1, and in_ready stays 0 throughout.
5. Reset mid-operation: assert rst at round 5 -> the next cycle shows out_valid=0, busy=0, plaintext=0. Then run vector 2 -> correct result.
6. Back-to-back: run vectors 1 and 2 with out_ready tied to 1 -> the two results arrive 12 cycles apart, in order.
